// File: rtl/hvgen_param.sv
// Parametrised raster timing generator: pixel/line counters, blanking, syncs,
// blank-gated RGB and frame/line-start strobes, advanced by a pixel clock-enable.
module hvgen_param #(
  parameter int unsigned CW            = 9,
  parameter int unsigned DW            = 12,
  parameter int unsigned H_BLANK_START = 289,
  parameter int unsigned H_SYNC_START  = 311,
  parameter int unsigned H_SYNC_END    = 342,
  parameter int unsigned H_JUMP        = 342,
  parameter int unsigned H_RESTART     = 471,
  parameter int unsigned V_BLANK_START = 223,
  parameter int unsigned V_SYNC_START  = 235,
  parameter int unsigned V_SYNC_END    = 242,
  parameter int unsigned V_JUMP        = 242,
  parameter int unsigned V_RESTART     = 492
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          CE_PIX,
  input  logic [3:0]    H_OFS,
  input  logic [3:0]    V_OFS,
  input  logic [DW-1:0] iRGB,
  output logic [CW-1:0] HPOS,
  output logic [CW-1:0] VPOS,
  output logic [DW-1:0] oRGB,
  output logic          HBLK,
  output logic          VBLK,
  output logic          HSYN,
  output logic          VSYN,
  output logic          FSTART,
  output logic          LSTART
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] HBS     = CW'(H_BLANK_START);
  localparam logic [CW-1:0] HSS     = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HSE     = CW'(H_SYNC_END);
  localparam logic [CW-1:0] HJMP    = CW'(H_JUMP);
  localparam logic [CW-1:0] HRST    = CW'(H_RESTART);
  localparam logic [CW-1:0] VBS     = CW'(V_BLANK_START);
  localparam logic [CW-1:0] VSS     = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VSE     = CW'(V_SYNC_END);
  localparam logic [CW-1:0] VJMP    = CW'(V_JUMP);
  localparam logic [CW-1:0] VRST    = CW'(V_RESTART);

  logic [CW-1:0] hcnt, hcnt_n;
  logic [CW-1:0] vcnt, vcnt_n;
  logic [3:0]    hofs, hofs_n;
  logic [3:0]    vofs, vofs_n;
  logic          hblk, hblk_n;
  logic          vblk, vblk_n;
  logic          hsyn, hsyn_n;
  logic          vsyn, vsyn_n;
  logic          fstart, fstart_n;
  logic          lstart, lstart_n;
  logic [DW-1:0] rgb, rgb_n;

  logic [CW-1:0] hofs_x, vofs_x;
  logic [CW-1:0] hs_on, hs_off, vs_on, vs_off;

  // Sync compare points: nominal count plus the frame-latched signed offset, modulo 2^CW.
  assign hofs_x = CW'($signed(hofs));
  assign vofs_x = CW'($signed(vofs));
  assign hs_on  = HSS + hofs_x;
  assign hs_off = HSE + hofs_x;
  assign vs_on  = VSS + vofs_x;
  assign vs_off = VSE + vofs_x;

  // Next-state: later assignments win, so jump/wrap loads and forced sync-high take priority.
  always_comb begin
    hcnt_n   = hcnt;
    vcnt_n   = vcnt;
    hofs_n   = hofs;
    vofs_n   = vofs;
    hblk_n   = hblk;
    vblk_n   = vblk;
    hsyn_n   = hsyn;
    vsyn_n   = vsyn;
    rgb_n    = rgb;
    fstart_n = 1'b0;
    lstart_n = 1'b0;
    if (CE_PIX) begin
      rgb_n  = (hblk | vblk) ? '0 : iRGB;
      hcnt_n = hcnt + CW'(1);
      if (hcnt == '0)     hblk_n = 1'b0;
      if (hcnt == HBS)    hblk_n = 1'b1;
      if (hcnt == hs_on)  hsyn_n = 1'b0;
      if (hcnt == hs_off) hsyn_n = 1'b1;
      if (hcnt == HJMP) begin
        hcnt_n = HRST;
        hsyn_n = 1'b1;
      end
      if (hcnt == CNT_MAX) begin
        hcnt_n   = '0;
        lstart_n = 1'b1;
        vcnt_n   = vcnt + CW'(1);
        if (vcnt == VBS)    vblk_n = 1'b1;
        if (vcnt == vs_on)  vsyn_n = 1'b0;
        if (vcnt == vs_off) vsyn_n = 1'b1;
        if (vcnt == VJMP) begin
          vcnt_n = VRST;
          vsyn_n = 1'b1;
        end
        if (vcnt == CNT_MAX) begin
          vcnt_n   = '0;
          vblk_n   = 1'b0;
          fstart_n = 1'b1;
          hofs_n   = H_OFS;
          vofs_n   = V_OFS;
        end
      end
    end
  end

  // State register; synchronous reset overrides the pixel enable.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      hcnt   <= '0;
      vcnt   <= '0;
      hofs   <= '0;
      vofs   <= '0;
      hblk   <= 1'b1;
      vblk   <= 1'b1;
      hsyn   <= 1'b1;
      vsyn   <= 1'b1;
      rgb    <= '0;
      fstart <= 1'b0;
      lstart <= 1'b0;
    end else begin
      hcnt   <= hcnt_n;
      vcnt   <= vcnt_n;
      hofs   <= hofs_n;
      vofs   <= vofs_n;
      hblk   <= hblk_n;
      vblk   <= vblk_n;
      hsyn   <= hsyn_n;
      vsyn   <= vsyn_n;
      rgb    <= rgb_n;
      fstart <= fstart_n;
      lstart <= lstart_n;
    end
  end

  assign HPOS   = hcnt;
  assign VPOS   = vcnt;
  assign oRGB   = rgb;
  assign HBLK   = hblk;
  assign VBLK   = vblk;
  assign HSYN   = hsyn;
  assign VSYN   = vsyn;
  assign FSTART = fstart;
  assign LSTART = lstart;

endmodule

// File: tb/tb_hvgen_param.sv
// Bench for hvgen_param: scoreboard against a sequence-index model on a reduced raster,
// plus line-level measurements on a default-parameter instance.
module tb_hvgen_param;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reduced raster keeps whole frames inside a short run.
  localparam int S_MAX  = 63;
  localparam int S_HBS  = 20, S_HSS = 26, S_HSE = 33, S_HJ = 36, S_HR = 52;
  localparam int S_VBS  = 12, S_VSS = 15, S_VSE = 19, S_VJ = 20, S_VR = 56;
  localparam int S_HLEN = S_HJ + 1 + S_MAX - S_HR + 1;
  localparam int S_VLEN = S_VJ + 1 + S_MAX - S_VR + 1;

  logic        s_rst = 1'b1, s_ce = 1'b0;
  logic [3:0]  s_hofs = '0, s_vofs = '0;
  logic [11:0] s_rgb = '0;
  logic [5:0]  s_hpos, s_vpos;
  logic [11:0] s_orgb;
  logic        s_hblk, s_vblk, s_hsyn, s_vsyn, s_fs, s_ls;

  logic        d_rst = 1'b1, d_ce = 1'b0;
  logic [3:0]  d_hofs = '0, d_vofs = '0;
  logic [11:0] d_rgb = 12'hABC;
  logic [8:0]  d_hpos, d_vpos;
  logic [11:0] d_orgb;
  logic        d_hblk, d_vblk, d_hsyn, d_vsyn, d_fs, d_ls;

  hvgen_param #(
    .CW(6), .DW(12),
    .H_BLANK_START(S_HBS), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE),
    .H_JUMP(S_HJ), .H_RESTART(S_HR),
    .V_BLANK_START(S_VBS), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE),
    .V_JUMP(S_VJ), .V_RESTART(S_VR)
  ) u_small (
    .MCLK(MCLK), .RESET(s_rst), .CE_PIX(s_ce), .H_OFS(s_hofs), .V_OFS(s_vofs),
    .iRGB(s_rgb), .HPOS(s_hpos), .VPOS(s_vpos), .oRGB(s_orgb),
    .HBLK(s_hblk), .VBLK(s_vblk), .HSYN(s_hsyn), .VSYN(s_vsyn),
    .FSTART(s_fs), .LSTART(s_ls)
  );

  hvgen_param u_dflt (
    .MCLK(MCLK), .RESET(d_rst), .CE_PIX(d_ce), .H_OFS(d_hofs), .V_OFS(d_vofs),
    .iRGB(d_rgb), .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_orgb),
    .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn), .VSYN(d_vsyn),
    .FSTART(d_fs), .LSTART(d_ls)
  );

  typedef struct packed {
    logic [5:0]  hpos;
    logic [5:0]  vpos;
    logic [11:0] rgb;
    logic        hblk, vblk, hsyn, vsyn, fs, ls;
  } exp_t;

  exp_t expq[$];
  exp_t cur, e_mon, g_mon;
  int   m_hi, m_vi, m_hofs, m_vofs;
  bit   m_seen;
  bit   rnd_ofs = 1'b0;
  logic [3:0] nxt_hofs = '0, nxt_vofs = '0;
  int   sb_cyc = 0;

  // A line/frame is the count sequence 0..jump followed by restart..max.
  function automatic int seq_val(input int i, input int j, input int r);
    return (i <= j) ? i : r + i - j - 1;
  endfunction

  function automatic int seq_idx(input int val, input int j, input int r);
    if (val <= j) return val;
    if (val >= r) return j + 1 + val - r;
    return -1;
  endfunction

  // Sync is low from the assert index up to the first of deassert or jump.
  function automatic bit in_sync(input int k, input int on_v, input int off_v,
                                 input int j, input int r);
    int a, e, stop;
    a    = seq_idx(on_v & S_MAX, j, r);
    e    = seq_idx(off_v & S_MAX, j, r);
    stop = j;
    if (e >= 0 && e < stop) stop = e;
    return (a >= 0) && (k >= a) && (k < stop);
  endfunction

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  task automatic model_step(input bit ce, input bit rst);
    int k, kv;
    bit lw, fw;
    if (rst) begin
      m_hi = 0; m_vi = 0; m_hofs = 0; m_vofs = 0; m_seen = 1'b0;
      cur = '0;
      cur.hblk = 1'b1; cur.vblk = 1'b1; cur.hsyn = 1'b1; cur.vsyn = 1'b1;
    end else if (!ce) begin
      cur.fs = 1'b0;
      cur.ls = 1'b0;
    end else begin
      k  = m_hi;
      lw = (k == S_HLEN - 1);
      cur.rgb  = (cur.hblk | cur.vblk) ? 12'h000 : s_rgb;
      cur.hblk = seq_val(k, S_HJ, S_HR) >= S_HBS;
      cur.hsyn = !in_sync(k, S_HSS + m_hofs, S_HSE + m_hofs, S_HJ, S_HR);
      cur.ls   = lw;
      cur.fs   = 1'b0;
      if (lw) begin
        kv = m_vi;
        fw = (kv == S_VLEN - 1);
        cur.vblk = fw ? 1'b0 : ((seq_val(kv, S_VJ, S_VR) >= S_VBS) || !m_seen);
        cur.vsyn = !in_sync(kv, S_VSS + m_vofs, S_VSE + m_vofs, S_VJ, S_VR);
        if (fw) begin
          cur.fs = 1'b1;
          m_seen = 1'b1;
          m_hofs = sx4(s_hofs);
          m_vofs = sx4(s_vofs);
        end
        m_vi = (kv + 1) % S_VLEN;
      end
      m_hi = (k + 1) % S_HLEN;
      cur.hpos = 6'(seq_val(m_hi, S_HJ, S_HR));
      cur.vpos = 6'(seq_val(m_vi, S_VJ, S_VR));
    end
  endtask

  task automatic s_cycle(input bit ce, input bit rst);
    @(negedge MCLK);
    if (rnd_ofs && $urandom_range(0, 99) == 0) begin
      nxt_hofs = 4'($urandom);
      nxt_vofs = 4'($urandom);
    end
    s_ce   = ce;
    s_rst  = rst;
    s_rgb  = 12'($urandom);
    s_hofs = nxt_hofs;
    s_vofs = nxt_vofs;
    model_step(ce, rst);
    expq.push_back(cur);
  endtask

  task automatic s_run(input int n, input int ce_pct);
    for (int i = 0; i < n; i++) s_cycle($urandom_range(0, 99) < ce_pct, 1'b0);
  endtask

  // Monitor: compares the small instance every cycle an expectation is pending.
  always begin
    @(posedge MCLK);
    #1;
    if (expq.size() > 0) begin
      e_mon = expq.pop_front();
      g_mon.hpos = s_hpos; g_mon.vpos = s_vpos; g_mon.rgb = s_orgb;
      g_mon.hblk = s_hblk; g_mon.vblk = s_vblk; g_mon.hsyn = s_hsyn;
      g_mon.vsyn = s_vsyn; g_mon.fs = s_fs; g_mon.ls = s_ls;
      n_total++;
      if (g_mon === e_mon) n_pass++;
      else $display("FAIL scoreboard cyc %0d: got hpos=%0d vpos=%0d rgb=%h hb=%b vb=%b hs=%b vs=%b fs=%b ls=%b, expected hpos=%0d vpos=%0d rgb=%h hb=%b vb=%b hs=%b vs=%b fs=%b ls=%b",
                    sb_cyc, g_mon.hpos, g_mon.vpos, g_mon.rgb, g_mon.hblk, g_mon.vblk, g_mon.hsyn,
                    g_mon.vsyn, g_mon.fs, g_mon.ls, e_mon.hpos, e_mon.vpos, e_mon.rgb, e_mon.hblk,
                    e_mon.vblk, e_mon.hsyn, e_mon.vsyn, e_mon.fs, e_mon.ls);
      sb_cyc++;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic d_reset_chk(input string pfx);
    chk({pfx, " HPOS"}, int'(d_hpos), 0);
    chk({pfx, " VPOS"}, int'(d_vpos), 0);
    chk({pfx, " HBLK"}, int'(d_hblk), 1);
    chk({pfx, " VBLK"}, int'(d_vblk), 1);
    chk({pfx, " HSYN"}, int'(d_hsyn), 1);
    chk({pfx, " VSYN"}, int'(d_vsyn), 1);
    chk({pfx, " oRGB"}, int'(d_orgb), 0);
    chk({pfx, " FSTART"}, int'(d_fs), 0);
    chk({pfx, " LSTART"}, int'(d_ls), 0);
  endtask

  // One full default line: gap idle MCLKs before each pixel step.
  task automatic d_line(input int gap, output int hblk_lo, output int hsyn_lo,
                        output int ls_cnt, output int ls_pos, output int after_jump,
                        output int hold_bad, output int rgb_nz);
    int prev;
    hblk_lo = 0; hsyn_lo = 0; ls_cnt = 0; ls_pos = -1; after_jump = -1;
    hold_bad = 0; rgb_nz = 0;
    prev = int'(d_hpos);
    for (int s = 0; s < 384; s++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge MCLK) d_ce = 1'b0;
        @(posedge MCLK);
        #1;
        if (int'(d_hpos) != prev || d_ls || d_fs) hold_bad++;
      end
      @(negedge MCLK) d_ce = 1'b1;
      @(posedge MCLK);
      #1;
      if (prev == 342) after_jump = int'(d_hpos);
      if (!d_hblk) hblk_lo++;
      if (!d_hsyn) hsyn_lo++;
      if (d_ls) begin ls_cnt++; ls_pos = int'(d_hpos); end
      if (d_orgb != 12'h000) rgb_nz++;
      prev = int'(d_hpos);
    end
    @(negedge MCLK) d_ce = 1'b0;
  endtask

  initial begin
    int hb, hs, lc, lp, aj, hbad, rnz;

    // Reduced-raster scoreboard run.
    s_cycle(1'b0, 1'b1);
    s_cycle(1'b1, 1'b1);
    s_run(3000, 75);
    nxt_hofs = 4'h3; nxt_vofs = 4'h0;
    s_run(3000, 75);
    nxt_hofs = 4'h8; nxt_vofs = 4'hE;
    s_run(3000, 80);
    for (int i = 0; i < 800; i++) s_cycle((i % 8) == 7, 1'b0);
    nxt_hofs = 4'h0; nxt_vofs = 4'h0;
    s_cycle(1'b1, 1'b1);
    rnd_ofs = 1'b1;
    s_run(6000, 85);
    s_cycle(1'b0, 1'b0);
    @(posedge MCLK);
    #2;
    chk("scoreboard drained", expq.size(), 0);

    // Default-parameter instance: reset, one slow line, mid-line reset, one fast line.
    @(negedge MCLK) begin d_rst = 1'b1; d_ce = 1'b1; end
    @(posedge MCLK);
    #1;
    d_reset_chk("por");
    @(negedge MCLK) begin d_rst = 1'b0; d_ce = 1'b0; end

    d_line(7, hb, hs, lc, lp, aj, hbad, rnz);
    chk("line1 HBLK low steps", hb, 289);
    chk("line1 HSYN low steps", hs, 31);
    chk("line1 LSTART count", lc, 1);
    chk("line1 LSTART at HPOS", lp, 0);
    chk("line1 HPOS after 342", aj, 471);
    chk("line1 idle hold errors", hbad, 0);
    chk("line1 oRGB nonzero in first frame", rnz, 0);
    chk("line1 end HPOS", int'(d_hpos), 0);
    chk("line1 end VPOS", int'(d_vpos), 1);

    for (int i = 0; i < 150; i++) begin
      @(negedge MCLK) d_ce = 1'b1;
    end
    @(negedge MCLK) d_ce = 1'b0;
    chk("pre-reset HPOS", int'(d_hpos), 150);
    @(negedge MCLK) begin d_rst = 1'b1; d_ce = 1'b1; end
    @(posedge MCLK);
    #1;
    d_reset_chk("midline");
    @(negedge MCLK) begin d_rst = 1'b0; d_ce = 1'b0; end

    d_line(0, hb, hs, lc, lp, aj, hbad, rnz);
    chk("line2 HBLK low steps", hb, 289);
    chk("line2 HSYN low steps", hs, 31);
    chk("line2 LSTART count", lc, 1);
    chk("line2 HPOS after 342", aj, 471);
    chk("line2 end VPOS", int'(d_vpos), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
